// File: rtl/mem_access_stage.sv
// MEM stage: drives the synchronous data SRAM from the EX result and aligns/extends load data for writeback.
// Build option MEM_MISALIGN_SPLIT_EN: split misaligned accesses into two SRAM cycles instead of suppressing them.
module mem_access_stage #(
  parameter int DM_AW = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_out,
  input  logic [31:0]      ex_rs2_data,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_mem_rd,
  input  logic             ex_mem_wr,
  input  logic             ex_reg_wen,
  input  logic [4:0]       ex_rd_addr,
  output logic             mem_stall,
  input  logic [31:0]      DM_OUT,
  output logic             DM_WEB,
  output logic [31:0]      DM_BWEB,
  output logic [DM_AW-1:0] DM_A,
  output logic [31:0]      DM_IN,
  output logic             wb_valid,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             misalign
);

  logic [1:0]       off;
  logic [3:0]       size_mask;
  logic             is_mis;
  logic             store_go;
  logic [DM_AW-1:0] word0;
  logic [3:0]       be_lo;
  logic [31:0]      d_lo;
  logic             cap_valid;
  logic             cap_mis;
  logic [31:0]      hi_src;
  logic [31:0]      lo_src;

  logic             v_q;
  logic             wen_q;
  logic             mis_q;
  logic             load_q;
  logic [4:0]       rd_q;
  logic [2:0]       f3_q;
  logic [31:0]      alu_q;
  logic [31:0]      rd_w;
  logic [31:0]      ld_ext;

  assign off      = ex_alu_out[1:0];
  assign word0    = ex_alu_out[DM_AW+1:2];
  // A write that coincides with reset is never issued.
  assign store_go = ex_valid & ex_mem_wr & ~rst;

  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign is_mis = (ex_mem_rd | ex_mem_wr) &
                  (((ex_funct3[1:0] == 2'b01) && (off == 2'd3)) ||
                   (ex_funct3[1] && (off != 2'd0)));

  function automatic logic [31:0] lane_mask_n(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{~be[i]}};
    return m;
  endfunction

`ifdef MEM_MISALIGN_SPLIT_EN
  // state  | meaning
  // IDLE   | word 0 of any access driven straight from EX
  // SECOND | word 1 of a split access driven from the captured registers
  typedef enum logic {IDLE, SECOND} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             split_start;
  logic             cap_split;
  logic             split_q;
  logic [7:0]       be8;
  logic [63:0]      d64;
  logic [DM_AW-1:0] a1_q;
  logic [31:0]      d1_q;
  logic [31:0]      m1_q;
  logic             wr1_q;
  logic [31:0]      lo_buf;

  assign be8         = {4'b0000, size_mask} << off;
  assign d64         = {32'b0, ex_rs2_data} << {off, 3'b000};
  assign be_lo       = be8[3:0];
  assign d_lo        = d64[31:0];
  assign split_start = (state == IDLE) & ex_valid & is_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a1_q    <= '0;
      d1_q    <= '0;
      m1_q    <= '1;
      wr1_q   <= 1'b0;
      lo_buf  <= '0;
      split_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      split_q <= cap_split;
      if (split_start) begin
        a1_q  <= word0 + DM_AW'(1);
        d1_q  <= d64[63:32];
        m1_q  <= lane_mask_n(be8[7:4]);
        wr1_q <= ex_mem_wr;
      end
      if (state == SECOND) lo_buf <= DM_OUT;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    DM_A      = word0;
    DM_IN     = d_lo;
    DM_WEB    = ~store_go;
    DM_BWEB   = store_go ? lane_mask_n(be_lo) : '1;
    cap_valid = ex_valid & ~split_start;
    cap_mis   = 1'b0;
    cap_split = 1'b0;
    case (state)
      IDLE: begin
        if (split_start) begin
          mem_stall = 1'b1;
          state_nxt = SECOND;
        end
      end
      SECOND: begin
        DM_A      = a1_q;
        DM_IN     = d1_q;
        DM_WEB    = ~(wr1_q & ~rst);
        DM_BWEB   = (wr1_q & ~rst) ? m1_q : '1;
        cap_split = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign hi_src = split_q ? DM_OUT : '0;
  assign lo_src = split_q ? lo_buf : DM_OUT;
`else
  logic st_ok;

  assign be_lo     = size_mask << off;
  assign d_lo      = ex_rs2_data << {off, 3'b000};
  assign st_ok     = store_go & ~is_mis;
  assign mem_stall = 1'b0;
  assign DM_A      = word0;
  assign DM_IN     = d_lo;
  assign DM_WEB    = ~st_ok;
  assign DM_BWEB   = st_ok ? lane_mask_n(be_lo) : '1;
  assign cap_valid = ex_valid;
  assign cap_mis   = is_mis;
  assign hi_src    = '0;
  assign lo_src    = DM_OUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      wen_q  <= 1'b0;
      mis_q  <= 1'b0;
      load_q <= 1'b0;
      rd_q   <= '0;
      f3_q   <= '0;
      alu_q  <= '0;
    end else begin
      v_q    <= cap_valid;
      wen_q  <= ex_reg_wen;
      mis_q  <= cap_mis;
      load_q <= ex_mem_rd;
      rd_q   <= ex_rd_addr;
      f3_q   <= ex_funct3;
      alu_q  <= ex_alu_out;
    end
  end

  assign rd_w = 32'({hi_src, lo_src} >> {alu_q[1:0], 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_w[7]}}, rd_w[7:0]};
      3'b001:  ld_ext = {{16{rd_w[15]}}, rd_w[15:0]};
      3'b100:  ld_ext = {24'b0, rd_w[7:0]};
      3'b101:  ld_ext = {16'b0, rd_w[15:0]};
      default: ld_ext = rd_w;
    endcase
  end

  assign wb_valid = v_q;
  assign wb_en    = v_q & wen_q & ~mis_q;
  assign misalign = v_q & mis_q;
  assign wb_addr  = rd_q;
  assign wb_data  = !v_q ? '0 : (load_q ? ld_ext : alu_q);

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte-level reference memory plus a synchronous SRAM model on the DM_* pins.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wen;
  logic [31:0] ex_alu_out, ex_rs2_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd_addr;
  logic        mem_stall;
  logic [31:0] DM_OUT;
  logic        DM_WEB;
  logic [31:0] DM_BWEB, DM_IN;
  logic [13:0] DM_A;
  logic        wb_valid, wb_en, misalign;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] sram    [0:16383];
  logic [7:0]  ref_mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  logic        e_v, e_en, e_mis, e_chk;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  mem_access_stage #(.DM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
    .ex_funct3(ex_funct3), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_reg_wen(ex_reg_wen), .ex_rd_addr(ex_rd_addr), .mem_stall(mem_stall),
    .DM_OUT(DM_OUT), .DM_WEB(DM_WEB), .DM_BWEB(DM_BWEB), .DM_A(DM_A), .DM_IN(DM_IN),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    DM_OUT <= sram[DM_A];
    if (DM_WEB === 1'b0) sram[DM_A] = (sram[DM_A] & DM_BWEB) | (DM_IN & ~DM_BWEB);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    return (s == 2 && a[1:0] == 2'd3) || (s == 4 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v = '0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = ref_mem[(a + 32'(i)) & 32'h0000FFFF];
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic lanes(input logic [31:0] a, input logic [31:0] rs2, input logic [2:0] f3,
                       input int w, output logic [31:0] bwe, output logic [31:0] din);
    int lane;
    bwe = '1;
    din = '0;
    for (int i = 0; i < size_of(f3); i++) begin
      lane = int'(a[1:0]) + i;
      if (lane / 4 == w) begin
        bwe[8*(lane%4) +: 8] = 8'h00;
        din[8*(lane%4) +: 8] = rs2[8*i +: 8];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wb();
    check("wb_valid", wb_valid, e_v);
    check("wb_en", wb_en, e_en);
    check("misalign", misalign, e_mis);
    if (e_v) check("wb_addr", wb_addr, e_addr);
    if (e_chk) check("wb_data", wb_data, e_data);
  endtask

  task automatic store_ref(input logic [31:0] a, input logic [31:0] rs2, input int nbytes);
    for (int i = 0; i < nbytes; i++) ref_mem[(a + 32'(i)) & 32'h0000FFFF] = rs2[8*i +: 8];
  endtask

  // Called just after a rising edge; returns just after the edge that retires the access.
  task automatic op(input logic v, input logic rd, input logic wr, input logic wen,
                    input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                    input logic [4:0] rdaddr);
    logic        mis_now, split, st_act;
    logic [31:0] bwe, din;
    logic [13:0] na;
    ex_valid = v; ex_mem_rd = rd; ex_mem_wr = wr; ex_reg_wen = wen;
    ex_funct3 = f3; ex_alu_out = addr; ex_rs2_data = data; ex_rd_addr = rdaddr;
    mis_now = (rd | wr) && misaligned(f3, addr);
    split   = SPLIT && v && mis_now;
    st_act  = v && wr && (SPLIT || !mis_now);
    @(negedge clk);
    check_wb();
    check("dm_a", DM_A, addr[15:2]);
    check("mem_stall", mem_stall, split);
    if (st_act) begin
      lanes(addr, data, f3, 0, bwe, din);
      check("dm_web", DM_WEB, 1'b0);
      check("dm_bweb", DM_BWEB, bwe);
      check("dm_in", DM_IN & ~bwe, din & ~bwe);
    end else begin
      check("dm_web_idle", DM_WEB, 1'b1);
      check("dm_bweb_idle", DM_BWEB, 32'hFFFF_FFFF);
    end
    if (split) begin
      @(posedge clk); #1;
      @(negedge clk);
      na = addr[15:2] + 14'd1;
      check("split_wb_valid", wb_valid, 1'b0);
      check("split_stall", mem_stall, 1'b0);
      check("split_dm_a", DM_A, na);
      if (wr) begin
        lanes(addr, data, f3, 1, bwe, din);
        check("split_dm_web", DM_WEB, 1'b0);
        check("split_dm_bweb", DM_BWEB, bwe);
        check("split_dm_in", DM_IN & ~bwe, din & ~bwe);
      end else begin
        check("split_dm_web_rd", DM_WEB, 1'b1);
      end
    end
    if (st_act) store_ref(addr, data, size_of(f3));
    e_v = v;
    e_addr = rdaddr;
    if (!v) begin
      e_en = 1'b0; e_mis = 1'b0; e_data = '0; e_chk = 1'b1;
    end else begin
      e_mis  = mis_now && !SPLIT;
      e_en   = wen && !e_mis;
      e_chk  = !(rd && e_mis);
      e_data = rd ? load_value(addr, f3) : addr;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f3s [5];
    logic [31:0] a;
    int          kind;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int w = 0; w < 16384; w++) begin
      r = $urandom;
      sram[w] = r;
      for (int k = 0; k < 4; k++) ref_mem[4*w + k] = r[8*k +: 8];
    end

    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_wen = 1'b0;
    ex_funct3 = '0; ex_alu_out = '0; ex_rs2_data = '0; ex_rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_wb_addr", wb_addr, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_stall", mem_stall, 1'b0);
    check("rst_dm_web", DM_WEB, 1'b1);
    check("rst_dm_bweb", DM_BWEB, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    e_v = 1'b0; e_en = 1'b0; e_mis = 1'b0; e_chk = 1'b1; e_addr = '0; e_data = '0;

    op(1, 0, 1, 0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    op(1, 0, 1, 0, 3'b000, 32'h0000_0013, 32'h0000_00A5, 5'd0);
    op(1, 0, 1, 0, 3'b010, 32'h0000_0010, 32'h0080_0000, 5'd0);
    op(1, 1, 0, 1, 3'b000, 32'h0000_0012, 32'h0, 5'd5);
    op(1, 1, 0, 1, 3'b100, 32'h0000_0012, 32'h0, 5'd6);
    op(1, 0, 0, 1, 3'b011, 32'h0000_1234, 32'h0, 5'd7);
    op(1, 0, 1, 0, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 5'd0);
    op(1, 1, 0, 1, 3'b010, 32'h0000_0020, 32'h0, 5'd8);
    op(1, 0, 1, 0, 3'b010, 32'h0000_000C, 32'h4433_2211, 5'd0);
    op(1, 0, 1, 0, 3'b010, 32'h0000_0010, 32'h8877_6655, 5'd0);
    op(1, 1, 0, 1, 3'b010, 32'h0000_000E, 32'h0, 5'd9);
    op(1, 0, 1, 0, 3'b001, 32'h0000_000B, 32'h1234_BEEF, 5'd0);
    op(1, 1, 0, 1, 3'b101, 32'h0000_000A, 32'h0, 5'd10);
    op(0, 0, 1, 1, 3'b010, 32'h0000_0040, 32'h5555_5555, 5'd11);
    op(1, 1, 0, 1, 3'b010, 32'h0000_0040, 32'h0, 5'd12);

`ifdef MEM_MISALIGN_SPLIT_EN
    op(1, 0, 1, 0, 3'b010, 32'h0000_FFFE, 32'hA1B2_C3D4, 5'd0);
    op(1, 1, 0, 1, 3'b010, 32'h0000_FFFE, 32'h0, 5'd13);
    // Reset lands while word 1 of a split store is on the pins.
    ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b1; ex_reg_wen = 1'b0;
    ex_funct3 = 3'b010; ex_alu_out = 32'h0000_FFFE; ex_rs2_data = 32'h1357_2468; ex_rd_addr = 5'd0;
    @(negedge clk);
    check_wb();
    check("rsplit_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_valid = 1'b0; ex_mem_wr = 1'b0;
    store_ref(32'h0000_FFFE, 32'h1357_2468, 2);
    @(negedge clk);
    check("rsplit_dm_web", DM_WEB, 1'b1);
    check("rsplit_dm_bweb", DM_BWEB, 32'hFFFF_FFFF);
    check("rsplit_stall0", mem_stall, 1'b0);
    check("rsplit_wb_valid", wb_valid, 1'b0);
    check("rsplit_wb_en", wb_en, 1'b0);
    check("rsplit_misalign", misalign, 1'b0);
    check("rsplit_wb_addr", wb_addr, 5'd0);
    check("rsplit_wb_data", wb_data, 32'd0);
    e_v = 1'b0; e_en = 1'b0; e_mis = 1'b0; e_chk = 1'b1; e_data = '0;
    @(posedge clk); #1;
    op(1, 1, 0, 1, 3'b010, 32'h0000_0000, 32'h0, 5'd14);
    op(1, 1, 0, 1, 3'b010, 32'h0000_FFFC, 32'h0, 5'd15);
`endif

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'h0000_FFC0 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_0000);
      case (kind)
        0: op(0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, f3s[$urandom_range(0, 4)], a, $urandom, 5'($urandom));
        1: op(1, 1, 0, 1, f3s[$urandom_range(0, 4)], a, $urandom, 5'($urandom));
        2: op(1, 0, 1, 0, f3s[$urandom_range(0, 2)], a, $urandom, 5'($urandom));
        default: op(1, 0, 0, 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, 5'($urandom));
      endcase
    end
    op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
